// File: rtl/hazard_unit_ms.sv
// ID-stage hazard detector with programmable multi-cycle stall lengths and
// saturating stall/hazard performance counters.
module hazard_unit_ms #(
  parameter int INSTR_W       = 32,
  parameter int REG_W         = 5,
  parameter int LOAD_STALL    = 1,
  parameter int BR_ALU_STALL  = 1,
  parameter int BR_LOAD_STALL = 2,
  parameter int CNT_W         = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [INSTR_W-1:0] if_id_instr_i,
  input  logic               id_uses_rs_i,
  input  logic               id_uses_rt_i,
  input  logic               id_is_branch_i,
  input  logic               id_ex_memrd_i,
  input  logic               id_ex_regwr_i,
  input  logic [REG_W-1:0]   id_ex_rd_i,
  input  logic               ex_mem_memrd_i,
  input  logic [REG_W-1:0]   ex_mem_rd_i,
  input  logic               flush_i,
  input  logic               clr_cnt_i,
  output logic               pc_stall_o,
  output logic               if_id_hold_o,
  output logic               id_ex_bubble_o,
  output logic [CNT_W-1:0]   stall_cyc_o,
  output logic [CNT_W-1:0]   hazard_cnt_o
);

  localparam int MAX_AB    = (LOAD_STALL > BR_ALU_STALL) ? LOAD_STALL : BR_ALU_STALL;
  localparam int MAX_STALL = (MAX_AB > BR_LOAD_STALL) ? MAX_AB : BR_LOAD_STALL;
  localparam int REM_W     = $clog2(MAX_STALL + 1);

  localparam logic [REM_W-1:0] LD_N    = REM_W'(LOAD_STALL);
  localparam logic [REM_W-1:0] BR_AL_N = REM_W'(BR_ALU_STALL);
  localparam logic [REM_W-1:0] BR_LD_N = REM_W'(BR_LOAD_STALL);

  logic [REG_W-1:0] rs, rt;
  logic [REM_W-1:0] need, rem;
  logic             hit_ex, hit_mem, stall, new_event;

  function automatic logic reg_match(input logic [REG_W-1:0] r,
                                     input logic [REG_W-1:0] a_rs,
                                     input logic [REG_W-1:0] a_rt,
                                     input logic             u_rs,
                                     input logic             u_rt);
    return (r != '0) && ((u_rs && (r == a_rs)) || (u_rt && (r == a_rt)));
  endfunction

  function automatic logic [REM_W-1:0] max_of(input logic [REM_W-1:0] a,
                                              input logic [REM_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign rs = if_id_instr_i[21 +: REG_W];
  assign rt = if_id_instr_i[16 +: REG_W];

  // Stage: hazard classification; the longest applicable stall wins
  always_comb begin
    hit_ex  = reg_match(id_ex_rd_i, rs, rt, id_uses_rs_i, id_uses_rt_i);
    hit_mem = reg_match(ex_mem_rd_i, rs, rt, id_uses_rs_i, id_uses_rt_i);
    need    = '0;
    if (id_ex_memrd_i && hit_ex)
      need = max_of(need, LD_N);
    if (id_is_branch_i && id_ex_regwr_i && !id_ex_memrd_i && hit_ex)
      need = max_of(need, BR_AL_N);
    if (id_is_branch_i && id_ex_memrd_i && hit_ex)
      need = max_of(need, BR_LD_N);
    if (id_is_branch_i && ex_mem_memrd_i && hit_mem)
      need = max_of(need, LD_N);
  end

  // Outputs are gated by reset so an asserted rst_n_i drops them without a clock
  assign stall          = rst_n_i && ((rem != '0) || (need != '0));
  assign new_event      = (rem == '0) && (need != '0) && !flush_i;
  assign pc_stall_o     = stall && !flush_i;
  assign if_id_hold_o   = pc_stall_o;
  assign id_ex_bubble_o = pc_stall_o;

  // Stage: remaining-stall register; the detecting cycle is the first stall cycle
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rem <= '0;
    end else if (flush_i) begin
      rem <= '0;
    end else if (rem != '0) begin
      rem <= rem - 1'b1;
    end else if (need != '0) begin
      rem <= need - 1'b1;
    end
  end

  // Stage: performance counters
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cyc_o  <= '0;
      hazard_cnt_o <= '0;
    end else if (clr_cnt_i) begin
      stall_cyc_o  <= '0;
      hazard_cnt_o <= '0;
    end else begin
      if (pc_stall_o) stall_cyc_o  <= sat_inc(stall_cyc_o);
      if (new_event)  hazard_cnt_o <= sat_inc(hazard_cnt_o);
    end
  end

endmodule

// File: tb/tb_hazard_unit_ms.sv
// Bench for hazard_unit_ms: a default instance and a LOAD_STALL=3 / 3-bit-counter
// instance share stimulus and are compared against a stall-count reference model.
module tb_hazard_unit_ms;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        uses_rs, uses_rt, is_br, ex_memrd, ex_regwr, mem_memrd, flush, clr;
  logic [4:0]  ex_rd, mem_rd;

  logic        a_pc, a_hold, a_bub;
  logic [15:0] a_sc, a_hc;
  logic        b_pc, b_hold, b_bub;
  logic [2:0]  b_sc, b_hc;

  int n_cmp = 0;
  int n_err = 0;

  int m_rem[2];
  int m_sc[2];
  int m_hc[2];
  int ls[2]   = '{1, 3};
  int cmax[2] = '{65535, 7};

  always #5 clk = ~clk;

  hazard_unit_ms dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .if_id_instr_i(instr),
    .id_uses_rs_i(uses_rs), .id_uses_rt_i(uses_rt), .id_is_branch_i(is_br),
    .id_ex_memrd_i(ex_memrd), .id_ex_regwr_i(ex_regwr), .id_ex_rd_i(ex_rd),
    .ex_mem_memrd_i(mem_memrd), .ex_mem_rd_i(mem_rd), .flush_i(flush), .clr_cnt_i(clr),
    .pc_stall_o(a_pc), .if_id_hold_o(a_hold), .id_ex_bubble_o(a_bub),
    .stall_cyc_o(a_sc), .hazard_cnt_o(a_hc)
  );

  hazard_unit_ms #(.LOAD_STALL(3), .CNT_W(3)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .if_id_instr_i(instr),
    .id_uses_rs_i(uses_rs), .id_uses_rt_i(uses_rt), .id_is_branch_i(is_br),
    .id_ex_memrd_i(ex_memrd), .id_ex_regwr_i(ex_regwr), .id_ex_rd_i(ex_rd),
    .ex_mem_memrd_i(mem_memrd), .ex_mem_rd_i(mem_rd), .flush_i(flush), .clr_cnt_i(clr),
    .pc_stall_o(b_pc), .if_id_hold_o(b_hold), .id_ex_bubble_o(b_bub),
    .stall_cyc_o(b_sc), .hazard_cnt_o(b_hc)
  );

  function automatic bit hit(input logic [4:0] r);
    logic [4:0] rs, rt;
    rs = instr[25:21];
    rt = instr[20:16];
    return (r != 0) && ((uses_rs && r == rs) || (uses_rt && r == rt));
  endfunction

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Required stall length from the class rules (instance k differs only in LOAD_STALL)
  function automatic int need(input int k);
    int n = 0;
    if (ex_memrd && hit(ex_rd))                          n = mx(n, ls[k]);
    if (is_br && ex_regwr && !ex_memrd && hit(ex_rd))    n = mx(n, 1);
    if (is_br && ex_memrd && hit(ex_rd))                 n = mx(n, 2);
    if (is_br && mem_memrd && hit(mem_rd))               n = mx(n, ls[k]);
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    assert (obs === 32'(exp))
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int e[2];
    for (int k = 0; k < 2; k++)
      e[k] = (rst_n && !flush && (m_rem[k] > 0 || need(k) > 0)) ? 1 : 0;
    chk({tag, ".a_pc"},   32'(a_pc),   e[0]);
    chk({tag, ".a_hold"}, 32'(a_hold), e[0]);
    chk({tag, ".a_bub"},  32'(a_bub),  e[0]);
    chk({tag, ".a_sc"},   32'(a_sc),   m_sc[0]);
    chk({tag, ".a_hc"},   32'(a_hc),   m_hc[0]);
    chk({tag, ".b_pc"},   32'(b_pc),   e[1]);
    chk({tag, ".b_hold"}, 32'(b_hold), e[1]);
    chk({tag, ".b_bub"},  32'(b_bub),  e[1]);
    chk({tag, ".b_sc"},   32'(b_sc),   m_sc[1]);
    chk({tag, ".b_hc"},   32'(b_hc),   m_hc[1]);
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int n;
      bit st;
      n  = need(k);
      st = (m_rem[k] > 0) || (n > 0);
      if (clr) begin
        m_sc[k] = 0;
        m_hc[k] = 0;
      end else if (!flush) begin
        if (st) m_sc[k] = mx(0, (m_sc[k] < cmax[k]) ? m_sc[k] + 1 : cmax[k]);
        if (m_rem[k] == 0 && n > 0) m_hc[k] = (m_hc[k] < cmax[k]) ? m_hc[k] + 1 : cmax[k];
      end
      if (flush)            m_rem[k] = 0;
      else if (m_rem[k] > 0) m_rem[k] = m_rem[k] - 1;
      else if (n > 0)       m_rem[k] = n - 1;
    end
  endtask

  // Called at posedge+1: check mid-cycle, then advance one clock
  task automatic step(input string tag);
    #3;
    check_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input int rs_, input int rt_, input bit urs, input bit urt,
                        input bit br, input bit exm, input bit exw, input int exrd,
                        input bit mm, input int mrd);
    instr     = {6'($urandom), 5'(rs_), 5'(rt_), 16'($urandom)};
    uses_rs   = urs;
    uses_rt   = urt;
    is_br     = br;
    ex_memrd  = exm;
    ex_regwr  = exw;
    ex_rd     = 5'(exrd);
    mem_memrd = mm;
    mem_rd    = 5'(mrd);
    flush     = 1'b0;
    clr       = 1'b0;
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_rem[k] = 0;
      m_sc[k]  = 0;
      m_hc[k]  = 0;
    end
    #1;
    check_all(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    @(posedge clk);
    #1;
    do_reset("reset");

    // Load-use on rs
    set_in(8, 10, 1, 1, 0, 1, 1, 8, 0, 0);
    step("ld_use");
    idle_in();
    chk("ld_use.a_hc_const", 32'(a_hc), 1);
    chk("ld_use.a_sc_const", 32'(a_sc), 1);
    step("ld_use_t1");
    step("ld_use_t2");
    step("ld_use_t3");
    chk("ld_use.b_sc_const", 32'(b_sc), 3);
    chk("ld_use.b_hc_const", 32'(b_hc), 1);
    chk("ld_use.a_sc_after", 32'(a_sc), 1);

    // Branch after ALU write, after a load in EX, after a load in MEM
    set_in(5, 0, 1, 0, 1, 0, 1, 5, 0, 0);
    step("br_alu");
    idle_in();
    repeat (3) step("br_alu_t");
    set_in(5, 0, 1, 0, 1, 1, 1, 5, 0, 0);
    step("br_ld");
    idle_in();
    repeat (3) step("br_ld_t");
    set_in(5, 0, 1, 0, 1, 0, 0, 0, 1, 5);
    step("br_mem");
    idle_in();
    repeat (3) step("br_mem_t");

    // Register 0 and an unread rt never stall
    set_in(0, 0, 1, 1, 0, 1, 1, 0, 0, 0);
    step("r0");
    set_in(3, 8, 1, 0, 0, 1, 1, 8, 0, 0);
    step("rt_unused");

    // Flush in the second cycle of a branch-after-load stall
    set_in(5, 0, 1, 0, 1, 1, 1, 5, 0, 0);
    step("flush_s1");
    idle_in();
    flush = 1'b1;
    step("flush_s2");
    flush = 1'b0;
    repeat (2) step("flush_after");

    // Mid-stall input changes neither shorten nor extend the stall
    set_in(8, 10, 1, 1, 0, 1, 1, 8, 0, 0);
    step("hold_s1");
    set_in(5, 0, 1, 0, 1, 1, 1, 5, 0, 0);
    repeat (4) step("hold_chg");
    idle_in();
    repeat (3) step("hold_tail");

    // Clear together with a stall
    set_in(8, 10, 1, 1, 0, 1, 1, 8, 0, 0);
    clr = 1'b1;
    step("clr");
    chk("clr.a_sc_const", 32'(a_sc), 0);
    chk("clr.a_hc_const", 32'(a_hc), 0);
    chk("clr.b_sc_const", 32'(b_sc), 0);
    chk("clr.b_hc_const", 32'(b_hc), 0);
    idle_in();
    repeat (3) step("clr_tail");

    // Saturation of the 3-bit counters
    set_in(8, 10, 1, 1, 0, 1, 1, 8, 0, 0);
    repeat (10) step("sat");
    chk("sat.a_sc_const", 32'(a_sc), 10);
    chk("sat.b_sc_const", 32'(b_sc), 7);

    // Asynchronous reset in the middle of a stall
    idle_in();
    repeat (3) step("pre_rst");
    set_in(8, 10, 1, 1, 0, 1, 1, 8, 0, 0);
    step("rst_s1");
    do_reset("mid_rst");
    idle_in();
    step("post_rst");

    // Randomized operands over a small register range to provoke matches
    repeat (400) begin
      set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3),
             1'($urandom), $urandom_range(0, 3));
      flush = ($urandom_range(0, 9) == 0);
      clr   = ($urandom_range(0, 29) == 0);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
